// File: rtl/duc_interp_pkg.sv
// Shared types, halfband constants and arithmetic helpers for the DUC interpolator.
package ducPkg;
   localparam int SampleW    = 18;
   localparam int SumW       = 23;
   localparam int RoundShift = 4;

   typedef logic signed [SampleW-1:0] sample_t;
   typedef logic signed [SumW-1:0]    acc_t;

   typedef enum logic {PhaseEven = 1'b0, PhaseOdd = 1'b1} phase_t;

   // Tap0 weights the newest delay-line entry x0, Tap3 the oldest x3.
   localparam acc_t Tap0       = -23'sd1;
   localparam acc_t Tap1       = 23'sd9;
   localparam acc_t Tap2       = 23'sd9;
   localparam acc_t Tap3       = -23'sd1;
   localparam acc_t RoundConst = 23'sd8;
   localparam acc_t SatMax     = 23'sd131071;
   localparam acc_t SatMin     = -23'sd131072;

   function automatic acc_t widen(input sample_t s);
      return {{(SumW-SampleW){s[SampleW-1]}}, s};
   endfunction

   function automatic sample_t saturate(input acc_t v);
      sample_t result;
      if (v > SatMax)
         result = SatMax[SampleW-1:0];
      else if (v < SatMin)
         result = SatMin[SampleW-1:0];
      else
         result = v[SampleW-1:0];
      return result;
   endfunction
endpackage

// File: rtl/duc_interp_if.sv
// Baseband sample request/response and output sample stream of the interpolator.
interface ducIf;
   import ducPkg::*;

   logic    sampleReq;
   logic    sampleValid;
   sample_t iIn;
   sample_t qIn;
   sample_t iOut;
   sample_t qOut;
   logic    outClkEn;

   modport master (output sampleValid, iIn, qIn, input sampleReq, iOut, qOut, outClkEn);
   modport slave  (input sampleValid, iIn, qIn, output sampleReq, iOut, qOut, outClkEn);
endinterface

// File: rtl/duc_interp_hb.sv
// One rail of the 2x halfband interpolator: four-entry delay line and polyphase output register.
module halfbandInterp2
   import ducPkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    clear,
   input  logic    tick,
   input  logic    consume,
   input  logic    bypass,
   input  sample_t sampleIn,
   output sample_t sampleOut
);
   sample_t x0, x1, x2, x3;
   acc_t    tapSum;
   acc_t    rounded;
   acc_t    shifted;
   sample_t oddSample;

   // Odd polyphase branch: interpolated point between x2 and x1, rounded then clipped.
   always_comb begin
      tapSum    = Tap3 * widen(x3) + Tap2 * widen(x2) + Tap1 * widen(x1) + Tap0 * widen(x0);
      rounded   = tapSum + RoundConst;
      shifted   = rounded >>> RoundShift;
      oddSample = saturate(shifted);
   end

   // On a shifting tick the even output is x1 before the shift, which is x2 after it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x0        <= '0;
         x1        <= '0;
         x2        <= '0;
         x3        <= '0;
         sampleOut <= '0;
      end else begin
         if (clear) begin
            x0 <= '0;
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
         end else if (consume && !bypass) begin
            x0 <= sampleIn;
            x1 <= x0;
            x2 <= x1;
            x3 <= x2;
         end
         if (tick) begin
            if (bypass)
               sampleOut <= sampleIn;
            else if (consume)
               sampleOut <= x1;
            else
               sampleOut <= oddSample;
         end
      end
   end
endmodule

// File: rtl/duc_interp.sv
// DUC interpolator top: shared rate counter, phase, sample handshake and error flags driving I and Q rails.
module duc_interp
   import ducPkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] interpRatio,
   input  logic       bypassHb,
   input  logic       clearErr,
   output logic       underflow,
   output logic       overrun,
   ducIf.slave        bus
);
   logic [7:0] counter, counterNext;
   phase_t     phase, phaseNext;
   logic       holdFull, holdFullNext;
   logic       wasEnabled;
   logic       sampleReqReg, sampleReqNext;
   logic       outClkEnReg;
   sample_t    holdI, holdQ;
   sample_t    shiftI, shiftQ;
   sample_t    iOutRail, qOutRail;
   logic       tick, consume, captureHold, underflowSet, overrunSet;

   // A sample arriving on the consuming clock itself bypasses the hold register.
   always_comb begin
      tick          = enable && (counter == 8'd0);
      consume       = tick && ((phase == PhaseEven) || bypassHb);
      captureHold   = enable && bus.sampleValid && !holdFull && !consume;
      underflowSet  = consume && !holdFull && !bus.sampleValid;
      overrunSet    = enable && bus.sampleValid && holdFull;
      shiftI        = '0;
      shiftQ        = '0;
      counterNext   = tick ? interpRatio : counter - 8'd1;
      phaseNext     = phase;
      holdFullNext  = holdFull;
      sampleReqNext = !wasEnabled || consume;
      if (holdFull) begin
         shiftI = holdI;
         shiftQ = holdQ;
      end else if (bus.sampleValid) begin
         shiftI = bus.iIn;
         shiftQ = bus.qIn;
      end
      if (tick)
         phaseNext = (phase == PhaseEven) ? PhaseOdd : PhaseEven;
      if (consume)
         holdFullNext = 1'b0;
      else if (captureHold)
         holdFullNext = 1'b1;
      if (!enable) begin
         counterNext   = interpRatio;
         phaseNext     = PhaseOdd;
         holdFullNext  = 1'b0;
         sampleReqNext = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter      <= 8'd0;
         phase        <= PhaseOdd;
         holdFull     <= 1'b0;
         wasEnabled   <= 1'b0;
         sampleReqReg <= 1'b0;
         outClkEnReg  <= 1'b0;
         holdI        <= '0;
         holdQ        <= '0;
      end else begin
         counter      <= counterNext;
         phase        <= phaseNext;
         holdFull     <= holdFullNext;
         wasEnabled   <= enable;
         sampleReqReg <= sampleReqNext;
         outClkEnReg  <= tick;
         if (captureHold) begin
            holdI <= bus.iIn;
            holdQ <= bus.qIn;
         end
      end
   end

   // A set event wins over a simultaneous clear so no error is ever lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         underflow <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         underflow <= underflowSet || (underflow && !clearErr);
         overrun   <= overrunSet || (overrun && !clearErr);
      end
   end

   halfbandInterp2 railI (
      .clk       (clk),
      .reset     (reset),
      .clear     (!enable),
      .tick      (tick),
      .consume   (consume),
      .bypass    (bypassHb),
      .sampleIn  (shiftI),
      .sampleOut (iOutRail)
   );

   halfbandInterp2 railQ (
      .clk       (clk),
      .reset     (reset),
      .clear     (!enable),
      .tick      (tick),
      .consume   (consume),
      .bypass    (bypassHb),
      .sampleIn  (shiftQ),
      .sampleOut (qOutRail)
   );

   assign bus.sampleReq = sampleReqReg;
   assign bus.outClkEn  = outClkEnReg;
   assign bus.iOut      = iOutRail;
   assign bus.qOut      = qOutRail;
endmodule

// File: tb/tb_duc_interp.sv
// Scoreboard bench for duc_interp: random and directed sample streams against a behavioural reference.
module tb_duc_interp;
   import ducPkg::*;

   typedef struct {int i; int q;} pair_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] interpRatio = 8'd0;
   logic       bypassHb = 1'b0;
   logic       clearErr = 1'b0;
   logic       underflow, overrun;

   ducIf bus ();

   duc_interp dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .interpRatio (interpRatio),
      .bypassHb    (bypassHb),
      .clearErr    (clearErr),
      .underflow   (underflow),
      .overrun     (overrun),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    failures = 0;
   bit    monOn = 1'b0;
   bit    constMode = 1'b0;
   int    srcQ[$];
   int    capQ[$];
   pair_t expQ[$];

   // Reference state: tick countdown, which half of the output pair is next, pending sample, history.
   int mCnt;
   bit mOddNext;
   bit mHoldFull;
   int mHoldI, mHoldQ;
   int histI[4], histQ[4];
   bit mWasEn;
   bit expReq, expOutEn, expUnder, expOver;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Interpolated midpoint of a 4-point history (oldest first), floor-rounded and clipped to 18 bits.
   function automatic int oddRef(input int oldest, input int older, input int newer, input int newest);
      int num, q;
      num = 9 * (older + newer) - oldest - newest + 8;
      q = (num >= 0) ? num / 16 : -((15 - num) / 16);
      if (q > 131071) q = 131071;
      if (q < -131072) q = -131072;
      return q;
   endfunction

   task automatic modelReset();
      mCnt = 0; mOddNext = 1'b1; mHoldFull = 1'b0; mHoldI = 0; mHoldQ = 0;
      histI = '{0, 0, 0, 0}; histQ = '{0, 0, 0, 0};
      mWasEn = 1'b0; expReq = 1'b0; expOutEn = 1'b0; expUnder = 1'b0; expOver = 1'b0;
      expQ.delete();
   endtask

   task automatic modelStep();
      bit tk, cons, unSet, ovSet;
      int vi, vq;
      pair_t p;
      unSet = 1'b0; ovSet = 1'b0; vi = 0; vq = 0;
      if (!enable) begin
         mCnt = int'(interpRatio); mOddNext = 1'b1; mHoldFull = 1'b0;
         histI = '{0, 0, 0, 0}; histQ = '{0, 0, 0, 0};
         expReq = 1'b0; expOutEn = 1'b0; mWasEn = 1'b0;
      end else begin
         tk = (mCnt == 0);
         cons = tk && (!mOddNext || bypassHb);
         mCnt = tk ? int'(interpRatio) : mCnt - 1;
         if (tk) mOddNext = !mOddNext;
         expReq = !mWasEn || cons;
         mWasEn = 1'b1;
         expOutEn = tk;
         if (cons) begin
            if (mHoldFull) begin
               vi = mHoldI; vq = mHoldQ;
               if (bus.sampleValid) ovSet = 1'b1;
            end else if (bus.sampleValid) begin
               vi = int'(bus.iIn); vq = int'(bus.qIn);
            end else begin
               unSet = 1'b1;
            end
            mHoldFull = 1'b0;
         end else if (bus.sampleValid) begin
            if (mHoldFull) ovSet = 1'b1;
            else begin
               mHoldI = int'(bus.iIn); mHoldQ = int'(bus.qIn); mHoldFull = 1'b1;
            end
         end
         if (tk) begin
            if (bypassHb) begin
               p.i = vi; p.q = vq;
            end else if (cons) begin
               histI = '{histI[1], histI[2], histI[3], vi};
               histQ = '{histQ[1], histQ[2], histQ[3], vq};
               p.i = histI[1]; p.q = histQ[1];
            end else begin
               p.i = oddRef(histI[0], histI[1], histI[2], histI[3]);
               p.q = oddRef(histQ[0], histQ[1], histQ[2], histQ[3]);
            end
            expQ.push_back(p);
         end
      end
      expUnder = unSet || (expUnder && !clearErr);
      expOver  = ovSet || (expOver && !clearErr);
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) modelReset();
      else modelStep();
   end

   // Monitor: per-cycle strobes and flags, plus one scoreboard pop per output strobe.
   always @(negedge clk) begin
      pair_t e;
      if (monOn) begin
         checkOutput("sampleReq", int'(bus.sampleReq), int'(expReq));
         checkOutput("outClkEn", int'(bus.outClkEn), int'(expOutEn));
         checkOutput("underflow", int'(underflow), int'(expUnder));
         checkOutput("overrun", int'(overrun), int'(expOver));
         if (bus.outClkEn) begin
            capQ.push_back(int'(bus.iOut));
            if (expQ.size() == 0) begin
               checkOutput("unexpectedOutput", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("iOut", int'(bus.iOut), e.i);
               checkOutput("qOut", int'(bus.qOut), e.q);
            end
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".iOut"}, int'(bus.iOut), 0);
      checkOutput({tag, ".qOut"}, int'(bus.qOut), 0);
      checkOutput({tag, ".sampleReq"}, int'(bus.sampleReq), 0);
      checkOutput({tag, ".outClkEn"}, int'(bus.outClkEn), 0);
      checkOutput({tag, ".underflow"}, int'(underflow), 0);
      checkOutput({tag, ".overrun"}, int'(overrun), 0);
   endtask

   task automatic goIdle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         enable = 1'b0; bus.sampleValid = 1'b0; clearErr = 1'b0;
      end
   endtask

   // One negedge per clock: answer requests (maybe twice), stray valids, clears and mode changes.
   task automatic applyStimulus(input int ratio, input bit byp, input int cycles, input int validPct,
                                input int extraPct, input int dblPct, input int clearPct, input int mixPct);
      bit fire, dblPending;
      dblPending = 1'b0;
      interpRatio = 8'(ratio);
      bypassHb = byp;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         enable = 1'b1;
         if (mixPct > 0 && $urandom_range(99) < mixPct) bypassHb = !bypassHb;
         if (mixPct > 0 && $urandom_range(99) < mixPct) interpRatio = 8'($urandom_range(4));
         clearErr = ($urandom_range(99) < clearPct);
         fire = 1'b0;
         if (dblPending) begin
            fire = 1'b1; dblPending = 1'b0;
         end else if (bus.sampleReq && $urandom_range(99) < validPct) begin
            fire = 1'b1; dblPending = ($urandom_range(99) < dblPct);
         end else if ($urandom_range(99) < extraPct) begin
            fire = 1'b1;
         end
         bus.sampleValid = fire;
         if (fire) begin
            if (srcQ.size() > 0) begin
               bus.iIn = sample_t'(srcQ.pop_front()); bus.qIn = sample_t'($urandom);
            end else if (constMode) begin
               bus.iIn = 18'sd1000; bus.qIn = -18'sd1000;
            end else begin
               bus.iIn = sample_t'($urandom); bus.qIn = sample_t'($urandom);
            end
         end
      end
   endtask

   initial begin
      int impulseRef[10];
      impulseRef = '{0, 0, -1024, 0, 9216, 16384, 9216, 0, -1024, 0};
      bus.sampleValid = 1'b0; bus.iIn = '0; bus.qIn = '0;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("resetState");
      monOn = 1'b1;
      reset = 1'b1;

      $display("[TB] DC settle, ratio 3");
      constMode = 1'b1;
      applyStimulus(3, 1'b0, 200, 100, 0, 0, 0, 0);
      checkOutput("dcSettleI", int'(bus.iOut), 1000);
      checkOutput("dcSettleQ", int'(bus.qOut), -1000);
      constMode = 1'b0;

      $display("[TB] impulse response");
      goIdle(3);
      capQ.delete();
      srcQ = {16384, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      applyStimulus(1, 1'b0, 44, 100, 0, 0, 0, 0);
      checkOutput("impulseCount", int'(capQ.size() >= 10), 1);
      for (int k = 0; k < 10 && k < capQ.size(); k++)
         checkOutput($sformatf("impulse[%0d]", k), capQ[k], impulseRef[k]);
      srcQ.delete();

      $display("[TB] saturation");
      goIdle(3);
      capQ.delete();
      srcQ = {-131072, 131071, 131071, -131072, 0, 0, 0, 0};
      applyStimulus(0, 1'b0, 30, 100, 0, 0, 0, 0);
      checkOutput("satOddOut", (capQ.size() > 8) ? capQ[8] : -1, 131071);
      srcQ.delete();

      $display("[TB] underflow and clear");
      applyStimulus(2, 1'b0, 20, 0, 0, 0, 0, 0);
      checkOutput("underflowSticky", int'(underflow), 1);
      applyStimulus(2, 1'b0, 30, 0, 0, 0, 100, 0);
      applyStimulus(2, 1'b0, 60, 70, 0, 0, 10, 0);

      $display("[TB] overrun");
      goIdle(3);
      clearErr = 1'b1;
      @(negedge clk);
      clearErr = 1'b0;
      capQ.delete();
      srcQ = {500, 700};
      applyStimulus(3, 1'b0, 40, 100, 0, 100, 0, 0);
      checkOutput("overrunFirstKept", (capQ.size() > 5) ? capQ[5] : -1, 500);
      checkOutput("overrunSticky", int'(overrun), 1);

      $display("[TB] bypass with mid-run reset");
      applyStimulus(2, 1'b1, 60, 90, 5, 0, 5, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 checkAllZero("midRunReset");
      bus.sampleValid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      applyStimulus(2, 1'b1, 60, 90, 5, 0, 5, 0);

      $display("[TB] randomized mixed modes");
      for (int r = 0; r < 8; r++)
         applyStimulus($urandom_range(4), 1'($urandom_range(1)), 150, 85, 5, 10, 5, 2);

      goIdle(4);
      checkOutput("scoreboardDrained", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
